// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs and monitor status, bundled for the traffic-light monitor.
// master: the lamp source/observer side; slave: the monitor itself.
interface traffic_light_monitor_if;
    logic       g_in;
    logic       y_in;
    logic       r_in;
    logic [1:0] phase;
    logic [5:0] dwell;
    logic       fault;
    logic [3:0] fault_code;
    logic [7:0] fault_cnt;
    logic [7:0] cycle_cnt;

    modport master (
        output g_in, y_in, r_in,
        input  phase, dwell, fault, fault_code, fault_cnt, cycle_cnt
    );

    modport slave (
        input  g_in, y_in, r_in,
        output phase, dwell, fault, fault_code, fault_cnt, cycle_cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Run-time checker for traffic-light lamp encoding, phase order and dwell time.
// Define TLM_FAULT_LATCH_EN to make fault/fault_code sticky until rst.
module traffic_light_monitor #(
    parameter int GREEN_TICKS  = 16,
    parameter int YELLOW_TICKS = 6,
    parameter int RED_TICKS    = 16,
    parameter int STUCK_MARGIN = 4
) (
    input  logic                    clk_1hz,
    input  logic                    rst,
    traffic_light_monitor_if.slave  bus
);
    // State encoding doubles as the phase output encoding.
    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_RED    = 2'b10,
        S_SYNC   = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] dwell_q, dwell_d;
    logic       partial_q, partial_d;
    logic       stuck_q, stuck_d;
    logic       clean_q, clean_d;
    logic       fault_q, fault_d;
    logic [3:0] code_q, code_d;
    logic [7:0] fault_cnt_q, fault_cnt_d;
    logic [7:0] cycle_cnt_q, cycle_cnt_d;

    logic [2:0] lamps;
    logic       onehot;
    state_t     samp;
    logic [5:0] dwell_inc;
    logic [3:0] code_now;
    logic       legal;
    logic       cycle_hit;

    function automatic int req_ticks(input state_t s);
        case (s)
            S_GREEN:  return GREEN_TICKS;
            S_YELLOW: return YELLOW_TICKS;
            S_RED:    return RED_TICKS;
            default:  return 0;
        endcase
    endfunction

    assign lamps     = {bus.g_in, bus.y_in, bus.r_in};
    assign onehot    = (lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001);
    assign dwell_inc = (dwell_q == 6'd63) ? 6'd63 : dwell_q + 6'd1;

    always_comb begin
        case (lamps)
            3'b100:  samp = S_GREEN;
            3'b010:  samp = S_YELLOW;
            3'b001:  samp = S_RED;
            default: samp = S_SYNC;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        partial_d = partial_q;
        stuck_d   = stuck_q;
        clean_d   = clean_q;
        code_now  = 4'b0000;
        legal     = 1'b0;
        cycle_hit = 1'b0;

        if (!onehot) begin
            code_now[0] = 1'b1;
            state_d     = S_SYNC;
            dwell_d     = 6'd0;
            partial_d   = 1'b1;
            stuck_d     = 1'b0;
            clean_d     = 1'b0;
        end else if (state_q == S_SYNC) begin
            state_d   = samp;
            dwell_d   = 6'd1;
            partial_d = 1'b1;
            stuck_d   = 1'b0;
            clean_d   = 1'b0;
        end else if (samp == state_q) begin
            dwell_d = dwell_inc;
            if (!stuck_q && (int'(dwell_inc) == req_ticks(state_q) + STUCK_MARGIN + 1)) begin
                code_now[3] = 1'b1;
                stuck_d     = 1'b1;
                clean_d     = 1'b0;
            end
        end else begin
            legal = ((state_q == S_GREEN)  && (samp == S_YELLOW)) ||
                    ((state_q == S_YELLOW) && (samp == S_RED))    ||
                    ((state_q == S_RED)    && (samp == S_GREEN));
            code_now[1] = !legal;
            code_now[2] = !partial_q && (int'(dwell_q) != req_ticks(state_q));
            cycle_hit   = clean_q && (state_q == S_RED) && (samp == S_GREEN) && (code_now == 4'b0000);
            state_d     = samp;
            dwell_d     = 6'd1;
            partial_d   = !legal;
            stuck_d     = 1'b0;
            // A legal green entry opens a fresh cycle window; the fault on this tick
            // belongs to the red phase that just ended.
            if (samp == S_GREEN) clean_d = legal;
            else                 clean_d = clean_q && (code_now == 4'b0000);
        end

        fault_cnt_d = ((|code_now) && (fault_cnt_q != 8'hFF)) ? fault_cnt_q + 8'd1 : fault_cnt_q;
        cycle_cnt_d = cycle_cnt_q + {7'd0, cycle_hit};

`ifdef TLM_FAULT_LATCH_EN
        code_d  = code_q | code_now;
        fault_d = fault_q | (|code_now);
`else
        code_d  = code_now;
        fault_d = |code_now;
`endif
    end

    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state_q     <= S_SYNC;
            dwell_q     <= 6'd0;
            partial_q   <= 1'b1;
            stuck_q     <= 1'b0;
            clean_q     <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= 4'b0000;
            fault_cnt_q <= 8'd0;
            cycle_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            partial_q   <= partial_d;
            stuck_q     <= stuck_d;
            clean_q     <= clean_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            fault_cnt_q <= fault_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.phase      = state_q;
    assign bus.dwell      = dwell_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.fault_cnt  = fault_cnt_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: expected per-tick outputs are queued
// as lamps are driven and compared against outputs captured after each edge.
module tb_traffic_light_monitor;
    typedef struct packed {
        logic [1:0] ph;
        logic [5:0] dw;
        logic       f;
        logic [3:0] code;
        logic [7:0] fc;
        logic [7:0] cc;
    } obs_t;

    localparam logic [2:0] LG = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b001;

    logic clk_1hz = 1'b0;
    logic rst     = 1'b1;
    traffic_light_monitor_if bus();

    traffic_light_monitor dut (.clk_1hz(clk_1hz), .rst(rst), .bus(bus));

    always #5 clk_1hz = ~clk_1hz;

    obs_t       sb[$];
    obs_t       obs[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] sticky   = 4'b0000;

    function automatic string fmt(input obs_t v);
        return $sformatf("ph=%b dw=%0d f=%b code=%b fc=%0d cc=%0d", v.ph, v.dw, v.f, v.code, v.fc, v.cc);
    endfunction

    function automatic obs_t sample();
        obs_t v;
        v = {bus.phase, bus.dwell, bus.fault, bus.fault_code, bus.fault_cnt, bus.cycle_cnt};
        return v;
    endfunction

    task automatic set_lamps(input logic [2:0] l);
        {bus.g_in, bus.y_in, bus.r_in} = l;
    endtask

    task automatic apply_reset();
        set_lamps(3'b000);
        rst = 1'b1;
        repeat (2) @(posedge clk_1hz);
        #1 rst = 1'b0;
        sticky = 4'b0000;
    endtask

    // Drive n ticks of one lamp pattern; code0 is the fault expected on the first tick only.
    task automatic run_seg(input logic [2:0] lamp, input int n, input logic [1:0] ph,
                           input int d0, input logic [3:0] code0, input int fc, input int cc);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e.ph   = ph;
            e.dw   = 6'((d0 + i > 63) ? 63 : d0 + i);
            e.code = (i == 0) ? code0 : 4'b0000;
`ifdef TLM_FAULT_LATCH_EN
            e.code = e.code | sticky;
            sticky = e.code;
`endif
            e.f  = |e.code;
            e.fc = 8'(fc);
            e.cc = 8'(cc);
            sb.push_back(e);
            set_lamps(lamp);
            @(posedge clk_1hz);
            #1 obs.push_back(sample());
        end
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst = 1'b1;
        set_lamps(LG);
        repeat (2) @(posedge clk_1hz);
        #1 o = sample();
        e = '{ph: 2'b11, dw: 6'd0, f: 1'b0, code: 4'b0000, fc: 8'd0, cc: 8'd0};
        n_assert++;
        if (o !== e) begin n_fail++; $display("FAIL reset_state got %s want %s", fmt(o), fmt(e)); end
        rst = 1'b0;
        sticky = 4'b0000;
    endtask

    task automatic test_nominal();
        obs_t o, e;
        int k = 0;
        apply_reset();
        run_seg(LG, 16, 2'b00, 1, 4'b0000, 0, 0);
        run_seg(LY,  6, 2'b01, 1, 4'b0000, 0, 0);
        run_seg(LR, 16, 2'b10, 1, 4'b0000, 0, 0);
        run_seg(LG, 16, 2'b00, 1, 4'b0000, 0, 0);
        run_seg(LY,  6, 2'b01, 1, 4'b0000, 0, 0);
        run_seg(LR, 16, 2'b10, 1, 4'b0000, 0, 0);
        run_seg(LG, 16, 2'b00, 1, 4'b0000, 0, 1);
        run_seg(LY,  6, 2'b01, 1, 4'b0000, 0, 1);
        run_seg(LR, 16, 2'b10, 1, 4'b0000, 0, 1);
        run_seg(LG,  1, 2'b00, 1, 4'b0000, 0, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); k++; n_assert++;
            if (o !== e) begin n_fail++; $display("FAIL nominal[%0d] got %s want %s", k, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_early_yellow();
        obs_t o, e;
        int k = 0;
        apply_reset();
        run_seg(LG, 16, 2'b00, 1, 4'b0000, 0, 0);
        run_seg(LY,  6, 2'b01, 1, 4'b0000, 0, 0);
        run_seg(LR, 16, 2'b10, 1, 4'b0000, 0, 0);
        run_seg(LG, 10, 2'b00, 1, 4'b0000, 0, 0);
        run_seg(LY,  6, 2'b01, 1, 4'b0100, 1, 0);
        run_seg(LR, 16, 2'b10, 1, 4'b0000, 1, 0);
        run_seg(LG,  2, 2'b00, 1, 4'b0000, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); k++; n_assert++;
            if (o !== e) begin n_fail++; $display("FAIL early_yellow[%0d] got %s want %s", k, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_illegal_order();
        obs_t o, e;
        int k = 0;
        apply_reset();
        run_seg(LG, 16, 2'b00, 1, 4'b0000, 0, 0);
        run_seg(LY,  6, 2'b01, 1, 4'b0000, 0, 0);
        run_seg(LR, 16, 2'b10, 1, 4'b0000, 0, 0);
        run_seg(LG, 16, 2'b00, 1, 4'b0000, 0, 0);
        run_seg(LR, 10, 2'b10, 1, 4'b0010, 1, 0);
        run_seg(LG, 10, 2'b00, 1, 4'b0000, 1, 0);
        run_seg(LR,  2, 2'b10, 1, 4'b0110, 2, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); k++; n_assert++;
            if (o !== e) begin n_fail++; $display("FAIL illegal_order[%0d] got %s want %s", k, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_bad_encoding();
        obs_t o, e;
        int k = 0;
        apply_reset();
        run_seg(LG,     5, 2'b00, 1, 4'b0000, 0, 0);
        run_seg(3'b110, 1, 2'b11, 0, 4'b0001, 1, 0);
        run_seg(LG,     8, 2'b00, 1, 4'b0000, 1, 0);
        run_seg(LY,     6, 2'b01, 1, 4'b0000, 1, 0);
        run_seg(LR,    16, 2'b10, 1, 4'b0000, 1, 0);
        run_seg(LG,     1, 2'b00, 1, 4'b0000, 1, 0);
        run_seg(3'b000, 1, 2'b11, 0, 4'b0001, 2, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); k++; n_assert++;
            if (o !== e) begin n_fail++; $display("FAIL bad_encoding[%0d] got %s want %s", k, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_stuck_red();
        obs_t o, e;
        int k = 0;
        apply_reset();
        run_seg(LR, 20, 2'b10,  1, 4'b0000, 0, 0);
        run_seg(LR,  1, 2'b10, 21, 4'b1000, 1, 0);
        run_seg(LR, 42, 2'b10, 22, 4'b0000, 1, 0);
        run_seg(LR,  5, 2'b10, 63, 4'b0000, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); k++; n_assert++;
            if (o !== e) begin n_fail++; $display("FAIL stuck_red[%0d] got %s want %s", k, fmt(o), fmt(e)); end
        end
        // Asynchronous reset between clock edges while red is still held.
        #3 rst = 1'b1;
        #1 o = sample();
        e = '{ph: 2'b11, dw: 6'd0, f: 1'b0, code: 4'b0000, fc: 8'd0, cc: 8'd0};
        n_assert++;
        if (o !== e) begin n_fail++; $display("FAIL async_reset got %s want %s", fmt(o), fmt(e)); end
        @(posedge clk_1hz);
        #1 o = sample();
        n_assert++;
        if (o !== e) begin n_fail++; $display("FAIL reset_hold got %s want %s", fmt(o), fmt(e)); end
        rst = 1'b0;
        sticky = 4'b0000;
    endtask

    initial begin
        set_lamps(3'b000);
        test_reset();
        test_nominal();
        test_early_yellow();
        test_illegal_order();
        test_bad_encoding();
        test_stuck_red();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
